// File: rtl/tron_pkg.sv
// Shared constants for the game display path: screen bounds, requester slots,
// sprite colours and the plot scheduler state encoding.
package tron_pkg;

   localparam int SCR_X_MAX = 159;
   localparam int SCR_Y_MAX = 119;

   localparam int REQ_P1    = 0;
   localparam int REQ_P2    = 1;
   localparam int REQ_P3    = 2;
   localparam int REQ_P4    = 3;
   localparam int REQ_TIMER = 4;
   localparam int N_REQ_ALL = 5;

   localparam logic [2:0] COL_P1    = 3'b001;
   localparam logic [2:0] COL_P2    = 3'b010;
   localparam logic [2:0] COL_P3    = 3'b100;
   localparam logic [2:0] COL_P4    = 3'b110;
   localparam logic [2:0] COL_TIMER = 3'b111;

   typedef enum logic {
      CLEAR = 1'b0,
      ARB   = 1'b1
   } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester at or after ptr, wrapping.
module rr_pick
   import tron_pkg::*;
#(
   parameter int N_REQ = N_REQ_ALL,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] win_oh,
   output logic [IW-1:0]    win_idx,
   output logic             any
);

   logic [IW-1:0] cand;

   // Scan N_REQ candidates starting at ptr; the first hit wins.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IW'((int'(ptr) + k) % N_REQ);
         if (!any && elig[cand]) begin
            any          = 1'b1;
            win_idx      = cand;
            win_oh[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/plot_scheduler.sv
// Shares the vga_adapter write port between pixel requesters and runs a
// full-screen clear sweep after reset or on request.
//
// state | meaning
// CLEAR | sweeping every pixel to CLEAR_COLOUR, requests ignored
// ARB   | round-robin grant of one requester pixel per cycle
module plot_scheduler
   import tron_pkg::*;
#(
   parameter int         N_REQ        = N_REQ_ALL,
   parameter logic [2:0] CLEAR_COLOUR = 3'b000,
   parameter int         X_MAX        = SCR_X_MAX,
   parameter int         Y_MAX        = SCR_Y_MAX
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic               clear_start,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_x,
   input  logic [7*N_REQ-1:0] req_y,
   input  logic [3*N_REQ-1:0] req_colour,
   output logic [N_REQ-1:0]   gnt,
   output logic [7:0]         x,
   output logic [6:0]         y,
   output logic [2:0]         colour,
   output logic               plot,
   output logic               clearing
);

   localparam int         IW     = $clog2(N_REQ);
   localparam logic [7:0] X_LAST = 8'(X_MAX);
   localparam logic [6:0] Y_LAST = 7'(Y_MAX);

   sched_state_t     state_q, state_d;
   logic [7:0]       cx_q, cx_d;
   logic [6:0]       cy_q, cy_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [7:0]       x_q, x_d;
   logic [6:0]       y_q, y_d;
   logic [2:0]       colour_q, colour_d;
   logic             plot_q, plot_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;

   logic [7:0]       rx [N_REQ];
   logic [6:0]       ry [N_REQ];
   logic [2:0]       rc [N_REQ];
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] win_oh;
   logic [IW-1:0]    win_idx;
   logic             any;

   // Split the flat requester buses into per-requester fields.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         rx[i] = req_x[8*i +: 8];
         ry[i] = req_y[7*i +: 7];
         rc[i] = req_colour[3*i +: 3];
      end
   end

   // gnt_q is the requester granted on the previous edge; it may still be
   // holding req high, so it sits out this round.
   assign elig = req & ~gnt_q;

   rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .elig    (elig),
      .ptr     (ptr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .any     (any)
   );

   // Next-state and next-output logic for the sweep and the arbiter.
   always_comb begin
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      ptr_d    = ptr_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      gnt_d    = '0;
      case (state_q)
         CLEAR: begin
            x_d      = cx_q;
            y_d      = cy_q;
            colour_d = CLEAR_COLOUR;
            plot_d   = 1'b1;
            if (cx_q == X_LAST) begin
               cx_d = '0;
               if (cy_q == Y_LAST) begin
                  cy_d    = '0;
                  state_d = ARB;
               end else begin
                  cy_d = cy_q + 1'b1;
               end
            end else begin
               cx_d = cx_q + 1'b1;
            end
         end
         ARB: begin
            if (clear_start) begin
               state_d = CLEAR;
               cx_d    = '0;
               cy_d    = '0;
            end else if (any) begin
               x_d      = rx[win_idx];
               y_d      = ry[win_idx];
               colour_d = rc[win_idx];
               gnt_d    = win_oh;
               // Off-screen pixels are consumed but never written.
               plot_d   = (rx[win_idx] <= X_LAST) && (ry[win_idx] <= Y_LAST);
               ptr_d    = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   // State, counters and registered adapter outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= CLEAR;
         cx_q     <= '0;
         cy_q     <= '0;
         ptr_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         gnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         ptr_q    <= ptr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         gnt_q    <= gnt_d;
      end
   end

   assign gnt      = gnt_q;
   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;
   assign plot     = plot_q;
   assign clearing = (state_q == CLEAR);

endmodule

// File: tb/tb_plot_scheduler.sv
// Bench for plot_scheduler: clear sweeps, round-robin grants, dropped pixels,
// clear requests and asynchronous reset.
module tb_plot_scheduler;
   import tron_pkg::*;

   localparam int NR = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clear_start;
   logic [NR-1:0]   req;
   logic [8*NR-1:0] req_x;
   logic [7*NR-1:0] req_y;
   logic [3*NR-1:0] req_colour;
   logic [NR-1:0]   gnt;
   logic [7:0]      x;
   logic [6:0]      y;
   logic [2:0]      colour;
   logic            plot;
   logic            clearing;

   logic [7:0] rx [NR];
   logic [6:0] ry [NR];
   logic [2:0] rc [NR];
   logic [7:0] rx0 [NR] = '{8'd10, 8'd30, 8'd50, 8'd70, 8'd90};
   logic [6:0] ry0 [NR] = '{7'd5, 7'd16, 7'd27, 7'd38, 7'd49};
   logic [2:0] rc0 [NR] = '{COL_P1, COL_P2, COL_P3, COL_P4, COL_TIMER};

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0] req;
      int         set_idx;
      logic [7:0] set_x;
      logic [6:0] set_y;
      logic [4:0] e_gnt;
      logic       e_plot;
      logic       chk_xyc;
      logic [7:0] e_x;
      logic [6:0] e_y;
      logic [2:0] e_c;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   plot_scheduler dut (
      .CLOCK_50    (clk),
      .resetn      (rst_n),
      .clear_start (clear_start),
      .req         (req),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_colour  (req_colour),
      .gnt         (gnt),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .plot        (plot),
      .clearing    (clearing)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         req_x[8*i +: 8]      = rx[i];
         req_y[7*i +: 7]      = ry[i];
         req_colour[3*i +: 3] = rc[i];
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] r, input int si, input logic [7:0] sx,
                               input logic [6:0] sy, input logic [4:0] eg, input logic ep,
                               input logic ck, input logic [7:0] ex, input logic [6:0] ey,
                               input logic [2:0] ec);
      vec_t v;
      v.req = r; v.set_idx = si; v.set_x = sx; v.set_y = sy;
      v.e_gnt = eg; v.e_plot = ep; v.chk_xyc = ck;
      v.e_x = ex; v.e_y = ey; v.e_c = ec;
      return v;
   endfunction

   // Checks n raster-order clear pixels, one per cycle, starting at (0,0).
   task automatic check_sweep(input int n, input bit pulse_cs, input string nm);
      int bad = 0;
      int first_bad = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (plot !== 1'b1 || x !== 8'(i % 160) || y !== 7'(i / 160) ||
             colour !== 3'b000 || gnt !== 5'b0 || clearing !== (i != 19199)) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
         if (pulse_cs) clear_start = (i >= 100 && i < 103);
      end
      if (bad != 0) $display("first bad sweep pixel index %0d", first_bad);
      chk(nm, bad, 0);
   endtask

   initial begin
      vec_t t;
      vec_t e;

      rst_n = 1'b0;
      clear_start = 1'b0;
      req = '0;
      for (int i = 0; i < NR; i++) begin
         rx[i] = rx0[i]; ry[i] = ry0[i]; rc[i] = rc0[i];
      end

      // Reset values, held over a few edges.
      #3;
      chk("rst_plot", plot, 1'b0);
      chk("rst_gnt", gnt, 5'b0);
      chk("rst_xyc", {x, y, colour}, 18'b0);
      chk("rst_clearing", clearing, 1'b1);
      repeat (3) @(negedge clk);
      chk("rst_hold_plot", plot, 1'b0);

      rst_n = 1'b1;
      check_sweep(19200, 1'b0, "sweep_after_reset");

      // Table: arbitration patterns starting from ptr=0.
      tbl.push_back(mk(5'b00000, -1, 8'd0, 7'd0, 5'b00000, 1'b0, 1'b1, 8'd159, 7'd119, 3'b000));
      for (int k = 0; k < 10; k++)
         tbl.push_back(mk(5'b11111, -1, 8'd0, 7'd0, 5'(1 << (k % 5)), 1'b1, 1'b1,
                          rx0[k % 5], ry0[k % 5], rc0[k % 5]));
      tbl.push_back(mk(5'b00000, -1, 8'd0, 7'd0, 5'b00000, 1'b0, 1'b1, 8'd90, 7'd49, COL_TIMER));
      for (int k = 0; k < 6; k++)
         tbl.push_back(mk(5'b00100, -1, 8'd0, 7'd0, (k % 2 == 0) ? 5'b00100 : 5'b00000,
                          (k % 2 == 0), 1'b1, 8'd50, 7'd27, COL_P3));
      tbl.push_back(mk(5'b00000, -1, 8'd0, 7'd0, 5'b00000, 1'b0, 1'b1, 8'd50, 7'd27, COL_P3));
      tbl.push_back(mk(5'b00010, 1, 8'd200, 7'd10, 5'b00010, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));
      tbl.push_back(mk(5'b00000, -1, 8'd0, 7'd0, 5'b00000, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));
      tbl.push_back(mk(5'b01000, 3, 8'd159, 7'd119, 5'b01000, 1'b1, 1'b1, 8'd159, 7'd119, COL_P4));
      tbl.push_back(mk(5'b10000, 4, 8'd0, 7'd120, 5'b10000, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));
      tbl.push_back(mk(5'b00000, 4, 8'd90, 7'd49, 5'b00000, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));
      tbl.push_back(mk(5'b10101, -1, 8'd0, 7'd0, 5'b00001, 1'b1, 1'b1, 8'd10, 7'd5, COL_P1));
      tbl.push_back(mk(5'b10101, -1, 8'd0, 7'd0, 5'b00100, 1'b1, 1'b1, 8'd50, 7'd27, COL_P3));
      tbl.push_back(mk(5'b10101, -1, 8'd0, 7'd0, 5'b10000, 1'b1, 1'b1, 8'd90, 7'd49, COL_TIMER));
      tbl.push_back(mk(5'b10101, -1, 8'd0, 7'd0, 5'b00001, 1'b1, 1'b1, 8'd10, 7'd5, COL_P1));
      tbl.push_back(mk(5'b00000, -1, 8'd0, 7'd0, 5'b00000, 1'b0, 1'b1, 8'd10, 7'd5, COL_P1));
      tbl.push_back(mk(5'b00010, 1, 8'd160, 7'd0, 5'b00010, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));
      tbl.push_back(mk(5'b00000, 1, 8'd30, 7'd16, 5'b00000, 1'b0, 1'b0, 8'd0, 7'd0, 3'b000));

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         if (t.set_idx >= 0) begin
            rx[t.set_idx] = t.set_x;
            ry[t.set_idx] = t.set_y;
         end
         req = t.req;
         exp_q.push_back(t);
         @(negedge clk);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_gnt", i), gnt, e.e_gnt);
         chk($sformatf("v%0d_plot", i), plot, e.e_plot);
         if (e.chk_xyc) begin
            chk($sformatf("v%0d_x", i), x, e.e_x);
            chk($sformatf("v%0d_y", i), y, e.e_y);
            chk($sformatf("v%0d_colour", i), colour, e.e_c);
         end
      end

      // clear_start in ARB with requester 0 pending: no grant, sweep restarts.
      req = 5'b00001;
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      chk("cs_gnt", gnt, 5'b0);
      chk("cs_plot", plot, 1'b0);
      chk("cs_clearing", clearing, 1'b1);
      check_sweep(19200, 1'b0, "sweep_after_clear_start");
      @(negedge clk);
      chk("cs_post_gnt", gnt, 5'b00001);
      chk("cs_post_plot", plot, 1'b1);
      chk("cs_post_xyc", {x, y, colour}, {8'd10, 7'd5, COL_P1});
      req = 5'b00000;

      // Reset mid-sweep at pixel (37,12), then a clean sweep that also
      // ignores a clear_start pulse part-way through.
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      check_sweep(12 * 160 + 38, 1'b0, "partial_sweep");
      chk("pre_rst_xy", {x, y}, {8'd37, 7'd12});
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_plot", plot, 1'b0);
      chk("mid_rst_xyc", {x, y, colour}, 18'b0);
      chk("mid_rst_gnt", gnt, 5'b0);
      chk("mid_rst_clearing", clearing, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      check_sweep(19200, 1'b1, "sweep_after_mid_reset");
      @(negedge clk);
      chk("end_plot", plot, 1'b0);
      chk("end_clearing", clearing, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/plot_scheduler.md
# plot_scheduler

Shares the single VGA adapter write port (x, y, colour, plot) among several pixel requesters: the four players, the timer bar and any later overlays. It also performs a full-screen clear sweep after reset and on request. It sits between the game logic and `vga_adapter` and replaces the fixed rotate-through-players sequencing with request-driven round-robin arbitration.

## Interface
Parameters:
- `N_REQ`, 5: number of requesters; index 0..3 are players 1..4, index 4 is the timer.
- `CLEAR_COLOUR`, 3'b000: colour written during a clear sweep.
- `X_MAX`, 159: last valid x on the 160x120 screen.
- `Y_MAX`, 119: last valid y.

Ports:
- `CLOCK_50`  in  1  single clock for the whole block.
- `resetn`  in  1  asynchronous, active-low reset.
- `clear_start`  in  1  level-sampled request to start a clear sweep.
- `req`  in  N_REQ  per-requester pixel request; held high until granted.
- `req_x`  in  8*N_REQ  x for requester i, in bits [8i+7:8i].
- `req_y`  in  7*N_REQ  y for requester i, in bits [7i+6:7i].
- `req_colour`  in  3*N_REQ  colour for requester i, in bits [3i+2:3i].
- `gnt`  out  N_REQ  one-hot, registered; requester i's pixel was consumed this cycle.
- `x`  out  8  pixel x to `vga_adapter`.
- `y`  out  7  pixel y to `vga_adapter`.
- `colour`  out  3  pixel colour to `vga_adapter`.
- `plot`  out  1  write strobe to `vga_adapter`.
- `clearing`  out  1  high while the state is CLEAR.

## Operation
The block has two states, CLEAR and ARB.

CLEAR:
- Internal counters `cx` (8 bit) and `cy` (7 bit) sweep x inner 0..X_MAX and y outer 0..Y_MAX.
- Each edge registers x=cx, y=cy, colour=CLEAR_COLOUR, plot=1, then advances the counters.
- `gnt` stays 0 and `req` is ignored.
- On the edge that outputs (X_MAX, Y_MAX): counters return to 0 and the state becomes ARB.
- `clear_start` is ignored while in CLEAR; the sweep is not restarted.

ARB:
- If `clear_start`=1 on an edge: the state becomes CLEAR with counters at 0. No grant is issued on that edge and plot=0.
- Otherwise, eligible = `req` with the requester granted on the previous edge masked off. This prevents a double grant before that requester sees `gnt` and drops `req`.
- Winner is the first eligible index at or after pointer `ptr`, wrapping modulo N_REQ.
- The winner's x, y and colour are registered to the outputs, `gnt`[winner]=1, and `ptr` becomes winner+1 (wrapping N_REQ-1 to 0).
- If the winner's x > X_MAX or y > Y_MAX, `gnt` is still issued but plot=0. The pixel is dropped.
- If nothing is eligible: plot=0, `gnt`=0, and x, y and colour hold their values.

## Timing
- Reset (asynchronous): state=CLEAR, cx=cy=0, ptr=0, previous-grant mask=0, x=0, y=0, colour=0, plot=0, gnt=0, clearing=1.
- The first clear pixel (0,0) appears after the first edge following reset release. The sweep takes exactly 19200 consecutive plot cycles. The earliest grant is on edge 19201.
- `clearing` falls in the same cycle that the last pixel (159,119) is on the outputs.
- Grant latency: a `req` sampled at edge k produces `gnt`, x, y, colour and plot all valid after edge k, for one cycle.
- A requester must drop or change `req` during the cycle in which it sees `gnt`. It is never re-granted on edge k+1.
- Throughput is one pixel per cycle while any request is eligible. With N_REQ requesters all held high, each is served once in every N_REQ grants.
- Reset asserted mid-sweep or mid-grant aborts immediately to the reset values. A full sweep follows reset release.

## Structure
- Shared package `tron_pkg`:
  - screen constants X_MAX=159 and Y_MAX=119
  - requester index constants REQ_P1..REQ_P4=0..3 and REQ_TIMER=4
  - player colour constants 3'b001, 3'b010, 3'b100, 3'b110, and timer colour 3'b111
  - state encoding CLEAR/ARB
- One combinational sub-module, `rr_pick`: inputs eligible vector and `ptr`; outputs one-hot winner, winner index and `any`.
- The FSM, sweep counters and output registers stay in `plot_scheduler`.

## Test plan
- Reset release with no requests -> exactly 19200 plot pulses covering (0,0)..(159,119) in raster order, all colour 0. Then `clearing`=0 and plot=0.
- After the sweep, `req`=5'b11111 held for 10 cycles with distinct coordinates -> grant order 0,1,2,3,4,0,1,2,3,4; plot=1 every cycle with matching x, y and colour.
- Requester 2 only, `req` held high continuously -> `gnt`[2] on alternate cycles only, never two consecutive cycles.
- `req`[1] with x=200, y=10 -> `gnt`[1]=1, plot=0, and x, y, colour are not forwarded to the adapter as a write.
- In ARB, `clear_start` pulsed while `req`=5'b00001 -> no grant on that edge, `clearing`=1, the sweep restarts at (0,0), and requester 0 is granted after the 19200th clear pixel.
- `resetn` asserted at sweep pixel (37,12) -> all outputs go to their reset values immediately. After release the sweep restarts at (0,0).
